// File: rtl/ex_alu_md_if.sv
// Execute-stage bus: operand selects, mul/div control and ALU results,
// shared between the pipeline (master) and the ALU (slave).
interface ex_alu_md_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PC;
    logic [3:0]      ALUctr;
    logic            ALUASrc;
    logic [1:0]      ALUBSrc;
    logic [XLEN-1:0] busA;
    logic [XLEN-1:0] busB;
    logic [XLEN-1:0] imm;
    logic            md_en;
    logic [2:0]      md_op;
    logic            flush;
    logic [XLEN-1:0] ALUout;
    logic [XLEN-1:0] Target;
    logic            Zero;
    logic            busy;
    logic            md_done;

    modport master (
        output PC, ALUctr, ALUASrc, ALUBSrc, busA, busB, imm, md_en, md_op, flush,
        input  ALUout, Target, Zero, busy, md_done
    );

    modport slave (
        input  PC, ALUctr, ALUASrc, ALUBSrc, busA, busB, imm, md_en, md_op, flush,
        output ALUout, Target, Zero, busy, md_done
    );
endinterface

// File: rtl/ex_alu_md.sv
// Execute-stage ALU: single-cycle integer ops plus an iterative
// shift-add multiplier / restoring divider that stalls the pipeline via busy.
module ex_alu_md #(
    parameter int XLEN = 32
) (
    input logic        clk,
    input logic        rst_n,
    ex_alu_md_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     opnd_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     res_q;

    logic [XLEN-1:0]        op_a;
    logic [XLEN-1:0]        op_b;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]         shamt;
    logic [XLEN-1:0]        alu_res;
    logic [XLEN-1:0]        alu_out;

    always_comb begin
        op_a = bus.ALUASrc ? bus.PC : bus.busA;
        case (bus.ALUBSrc)
            2'b00:   op_b = bus.busB;
            2'b01:   op_b = XLEN'(4);
            2'b10:   op_b = bus.imm;
            default: op_b = '0;
        endcase
    end

    assign a_s   = op_a;
    assign b_s   = op_b;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        case (bus.ALUctr)
            4'b0000: alu_res = op_a + op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0001: alu_res = op_a << shamt;
            4'b0101: alu_res = op_a >> shamt;
            4'b1101: alu_res = a_s >>> shamt;
            4'b1111: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Operand signedness per md_op; magnitudes feed the unsigned iteration core.
    logic            a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        case (bus.md_op)
            3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b011:                 begin a_sgn = 1'b1; b_sgn = 1'b0; end
            default:                begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
        a_neg    = a_sgn & op_a[XLEN-1];
        b_neg    = b_sgn & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        res_neg  = (bus.md_op == 3'b110) ? a_neg : (a_neg ^ b_neg);
        is_div   = bus.md_op[2];
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !bus.md_op[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero) spec_res = bus.md_op[1] ? op_a : '1;
        else          spec_res = bus.md_op[1] ? '0 : op_a;
    end

    // One iteration: multiply adds the multiplicand into the high half and shifts
    // right; divide shifts left and subtracts the divisor when it fits.
    logic [XLEN:0] mul_sum, rem_sh, rem_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (rem_diff[XLEN]) acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            else                acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            if (acc_q[0]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
            else          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    function automatic logic [XLEN-1:0] md_result(input logic [2:0] op, input logic neg,
                                                   input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op[2]) return (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        return op[1] ? rem : quo;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.md_en) begin
                        op_q   <= bus.md_op;
                        neg_q  <= res_neg;
                        opnd_q <= is_div ? b_mag : a_mag;
                        acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        cnt_q  <= CW'(XLEN);
                        if (div_zero || div_ovf) begin
                            res_q   <= spec_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_q   <= md_result(op_q, neg_q, acc_d);
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_out     = (state_q == DONE) ? res_q : alu_res;
    assign bus.ALUout  = alu_out;
    assign bus.Zero    = (alu_out == '0);
    assign bus.Target  = bus.PC + bus.imm;
    assign bus.busy    = ((state_q == IDLE) && bus.md_en && !bus.flush) || (state_q == RUN);
    assign bus.md_done = (state_q == DONE);
endmodule

// File: tb/tb_ex_alu_md.sv
// Directed bench for ex_alu_md: combinational ALU vectors plus a mul/div
// scoreboard checked by a monitor on every md_done pulse.
module tb_ex_alu_md;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ex_alu_md_if #(.XLEN(32)) bus ();

    ex_alu_md #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          issue;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every md_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.md_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL md_spurious: md_done=1 ALUout=%h expected no pulse", bus.ALUout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("md%0d_val", e.id), bus.ALUout, e.val);
                chk($sformatf("md%0d_zero", e.id), 32'(bus.Zero), 32'(e.val == 32'd0));
                chk($sformatf("md%0d_lat", e.id), 32'(cyc - e.issue), 32'(e.lat));
            end
        end
    end

    task automatic alu(input string name, input logic [3:0] ctr, input logic as, input logic [1:0] bs,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] pc, input logic [31:0] exp);
        @(negedge clk);
        bus.md_en = 1'b0; bus.ALUctr = ctr; bus.ALUASrc = as; bus.ALUBSrc = bs;
        bus.busA = a; bus.busB = b; bus.imm = im; bus.PC = pc;
        #1;
        chk(name, bus.ALUout, exp);
        chk({name, "_zero"}, 32'(bus.Zero), 32'(exp == 32'd0));
    endtask

    task automatic md_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.md_en = 1'b1; bus.md_op = op; bus.busA = a; bus.busB = b;
        bus.ALUASrc = 1'b0; bus.ALUBSrc = 2'b00; bus.ALUctr = 4'b0000;
    endtask

    task automatic md_idle();
        @(posedge clk); #1;
        bus.md_en = 1'b0;
    endtask

    task automatic md_run(input int id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ev, input int lat);
        bit got;
        bit busy_bad;
        got = 0;
        busy_bad = 0;
        md_start(op, a, b);
        exp_q.push_back('{id, ev, cyc, lat});
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            if (bus.md_done) got = 1;
            else if (!bus.busy) busy_bad = 1;
        end
        chk($sformatf("md%0d_finished", id), 32'(got), 32'd1);
        chk($sformatf("md%0d_busy_hold", id), 32'(busy_bad), 32'd0);
        chk($sformatf("md%0d_busy_done", id), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PC = '0; bus.ALUctr = '0; bus.ALUASrc = 1'b0; bus.ALUBSrc = '0;
        bus.busA = '0; bus.busB = '0; bus.imm = '0;
        bus.md_en = 1'b0; bus.md_op = '0; bus.flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.md_done), 32'd0);
        chk("rst_out", bus.ALUout, 32'd0);
        rst_n = 1'b1;

        // Single-cycle ALU
        alu("add_wrap", 4'b0000, 1'b0, 2'b10, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'h00000000);
        alu("slt",      4'b0010, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h00000001);
        alu("sltu",     4'b0011, 1'b0, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h00000000);
        alu("sra",      4'b1101, 1'b0, 2'b00, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'hF8000000);
        alu("srl",      4'b0101, 1'b0, 2'b00, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'h08000000);
        alu("sll",      4'b0001, 1'b0, 2'b00, 32'h00000001, 32'd31, 32'd0, 32'd0, 32'h80000000);
        alu("sub",      4'b1000, 1'b0, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFE);
        alu("xor",      4'b0100, 1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'h0FF00FF0);
        alu("and",      4'b0111, 1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'hF000F000);
        alu("or",       4'b0110, 1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 32'hFFF0FFF0);
        alu("pc_plus4", 4'b0000, 1'b1, 2'b01, 32'd9, 32'd9, 32'd0, 32'h100, 32'h00000104);
        alu("passb_b0", 4'b1111, 1'b0, 2'b11, 32'd9, 32'd9, 32'd9, 32'd0, 32'h00000000);
        alu("bad_code", 4'b1010, 1'b0, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 32'h00000000);
        alu("passb",    4'b1111, 1'b0, 2'b10, 32'd0, 32'd0, 32'h1234, 32'h100, 32'h00001234);
        bus.imm = 32'hFFFFFFF0; bus.PC = 32'h100;
        #1;
        chk("target", bus.Target, 32'h000000F0);

        // Multiply
        md_run(1, 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 33); md_idle();
        md_run(2, 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 33); md_idle();
        md_run(3, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33); md_idle();
        md_run(4, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33); md_idle();

        // Divide, including the special cases
        md_run(5,  3'b100, 32'd7, 32'd0, 32'hFFFFFFFF, 1); md_idle();
        md_run(6,  3'b110, 32'd7, 32'd0, 32'h00000007, 1); md_idle();
        md_run(7,  3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 1); md_idle();
        md_run(8,  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1); md_idle();
        md_run(9,  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1); md_idle();
        md_run(10, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33); md_idle();
        md_run(11, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33); md_idle();
        md_run(12, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33); md_idle();
        md_run(13, 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33); md_idle();
        md_run(14, 3'b110, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33); md_idle();

        // Flush on cycle 10 of a DIVU: no pulse, busy gone next cycle
        md_start(3'b101, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.md_en = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(posedge clk);
        md_run(15, 3'b000, 32'd5, 32'd6, 32'd30, 33); md_idle();

        // Reset mid-RUN
        md_start(3'b000, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        bus.md_en = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.md_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        md_run(16, 3'b111, 32'd100, 32'd7, 32'd2, 33); md_idle();

        // Back-to-back: second op enters EX in the IDLE cycle after DONE
        md_run(17, 3'b101, 32'd100, 32'd10, 32'd10, 33);
        md_run(18, 3'b000, 32'd3, 32'd4, 32'd12, 33);
        md_idle();

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
